// File: rtl/capp_pkg.sv
// Shared opcode and FSM state types for the content-addressable parallel processor.
package capp_pkg;

    typedef enum logic [2:0] {
        CAPP_NOP          = 3'd0,
        CAPP_SET_ALL      = 3'd1,
        CAPP_CLEAR_ALL    = 3'd2,
        CAPP_SEARCH       = 3'd3,
        CAPP_SELECT_FIRST = 3'd4,
        CAPP_WRITE        = 3'd5,
        CAPP_READ         = 3'd6,
        CAPP_SELECT_NEXT  = 3'd7
    } capp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } capp_state_t;

endpackage

// File: rtl/capp_if.sv
// Command/response bus between a host sequencer (master) and capp_engine (slave).
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. A source
// holds its valid and payload steady until the transfer happens.
interface capp_if #(
    parameter int NUM_BITS  = 8,
    parameter int NUM_CELLS = 16
);
    localparam int IDX_W = $clog2(NUM_CELLS);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [NUM_BITS-1:0] cmd_comparand;
    logic [NUM_BITS-1:0] cmd_mask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NUM_BITS-1:0] rsp_data;
    logic                rsp_some;
    logic [IDX_W-1:0]    rsp_first_idx;

    modport master (
        output cmd_valid, cmd_op, cmd_comparand, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_some, rsp_first_idx
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_comparand, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_some, rsp_first_idx
    );
endinterface

// File: rtl/capp_cell.sv
// One CAPP word plus its tag bit. The tag update is exposed combinationally
// (tag_next) so the top can register post-command status in the same edge.
module capp_cell
    import capp_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  capp_op_t            op,
    input  logic [NUM_BITS-1:0] c,
    input  logic [NUM_BITS-1:0] m,
    input  logic                first_hit,
    output logic                match,
    output logic                tag_next,
    output logic [NUM_BITS-1:0] word
);
    logic tag;
    logic key_hit;

    assign key_hit = (((word ^ c) & m) == '0);
    assign match   = tag;

    // Next tag value for the command being executed (holds when not executing).
    always_comb begin
        tag_next = tag;
        if (en) begin
            case (op)
                CAPP_SET_ALL:      tag_next = 1'b1;
                CAPP_CLEAR_ALL:    tag_next = 1'b0;
                CAPP_SEARCH:       tag_next = tag & key_hit;
                CAPP_SELECT_FIRST: tag_next = first_hit;
                CAPP_SELECT_NEXT:  tag_next = tag & ~first_hit;
                default:           tag_next = tag;
            endcase
        end
    end

    // Tag and word storage; masked write only touches tagged words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag  <= 1'b0;
            word <= '0;
        end else begin
            tag <= tag_next;
            if (en && op == CAPP_WRITE && tag) begin
                word <= (word & ~m) | (c & m);
            end
        end
    end

endmodule

// File: rtl/capp_engine.sv
// Content-addressable parallel processor with a valid/ready command/response bus.
// Optional feature: define CAPP_TAG_COUNT_EN to add the registered tag_count port.
module capp_engine
    import capp_pkg::*;
#(
    parameter int  NUM_BITS  = 8,
    parameter int  NUM_CELLS = 16,
    localparam int IDX_W     = $clog2(NUM_CELLS),
    localparam int CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    capp_if.slave                bus,
    output logic [NUM_CELLS-1:0] tag_wires,
`ifdef CAPP_TAG_COUNT_EN
    output logic [CNT_W-1:0]     tag_count,
`endif
    output capp_state_t          dbg_state
);
    capp_state_t         state, state_next;
    capp_op_t            op_q;
    logic [NUM_BITS-1:0] c_q, m_q;
    logic                exec_en;

    logic [NUM_CELLS-1:0] tags, tags_next, first_hit;
    logic [NUM_BITS-1:0]  words [NUM_CELLS];
    logic [NUM_BITS-1:0]  read_or;

    logic [NUM_BITS-1:0] rsp_data_q;
    logic                rsp_some_q;
    logic [IDX_W-1:0]    rsp_idx_q;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CELLS-1:0] t);
        lowest_idx = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (t[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    assign exec_en       = (state == ST_EXEC);
    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_some      = rsp_some_q;
    assign bus.rsp_first_idx = rsp_idx_q;
    assign tag_wires     = tags;
    assign dbg_state     = state;

    // Lowest set tag as a one-hot vector (two's-complement isolate).
    assign first_hit = tags & (~tags + NUM_CELLS'(1));

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next-state: one command in flight, response held until consumed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.cmd_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch on command acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q <= CAPP_NOP;
            c_q  <= '0;
            m_q  <= '0;
        end else if (state == ST_IDLE && bus.cmd_valid) begin
            op_q <= capp_op_t'(bus.cmd_op);
            c_q  <= bus.cmd_comparand;
            m_q  <= bus.cmd_mask;
        end
    end

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        capp_cell #(.NUM_BITS(NUM_BITS)) u_cell (
            .CLK       (CLK),
            .RST       (RST),
            .en        (exec_en),
            .op        (op_q),
            .c         (c_q),
            .m         (m_q),
            .first_hit (first_hit[g]),
            .match     (tags[g]),
            .tag_next  (tags_next[g]),
            .word      (words[g])
        );
    end

    // Masked OR of every tagged word for READ.
    always_comb begin
        read_or = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (tags[i]) read_or = read_or | (words[i] & m_q);
        end
    end

    // Response registers capture post-command status at the end of EXEC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_data_q <= '0;
            rsp_some_q <= 1'b0;
            rsp_idx_q  <= '0;
        end else if (exec_en) begin
            rsp_data_q <= (op_q == CAPP_READ) ? read_or : '0;
            rsp_some_q <= |tags_next;
            rsp_idx_q  <= lowest_idx(tags_next);
        end
    end

`ifdef CAPP_TAG_COUNT_EN
    logic [CNT_W-1:0] pop_next;

    // Popcount of post-command tags.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            pop_next = pop_next + CNT_W'(tags_next[i]);
        end
    end

    // Tag count register, updated together with the response.
    always_ff @(posedge CLK) begin
        if (RST)          tag_count <= '0;
        else if (exec_en) tag_count <= pop_next;
    end
`endif

endmodule

// File: tb/tb_capp_engine.sv
// Directed bench for capp_engine (NUM_BITS=4, NUM_CELLS=8) with a word/tag array model.
module tb_capp_engine;
    import capp_pkg::*;

    localparam int NB = 4;
    localparam int NC = 8;
    localparam int W  = 20;  // {data[3:0], some, idx[2:0], tags[7:0], cnt[3:0]}

    logic        CLK;
    logic        RST;
    logic [7:0]  tag_wires;
    logic [3:0]  tag_count;
    capp_state_t dbg_state;

    capp_if #(.NUM_BITS(NB), .NUM_CELLS(NC)) bus ();

    capp_engine #(.NUM_BITS(NB), .NUM_CELLS(NC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .tag_wires (tag_wires),
`ifdef CAPP_TAG_COUNT_EN
        .tag_count (tag_count),
`endif
        .dbg_state (dbg_state)
    );

`ifndef CAPP_TAG_COUNT_EN
    assign tag_count = '0;
`endif

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int bad = 0;
    bit started = 1'b0;

    logic [NB-1:0] m_words [NC];
    logic [NC-1:0] m_tags;
    logic [W-1:0]  exp_q [$];

    logic [3:0] last_data;
    logic       last_some;
    logic [2:0] last_idx;
    logic [7:0] last_tags;
    logic [3:0] last_cnt;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) m_words[i] = '0;
        m_tags = '0;
    endfunction

    // Apply one command to the array model and queue the response it implies.
    function automatic void model_apply(input logic [2:0] op, input logic [3:0] c, input logic [3:0] m);
        logic [3:0] d;
        logic       some;
        logic [2:0] idx;
        logic [3:0] cnt;
        bit         done;
        d = '0;
        done = 1'b0;
        case (op)
            3'd1: m_tags = '1;
            3'd2: m_tags = '0;
            3'd3: for (int i = 0; i < NC; i++)
                      m_tags[i] = m_tags[i] && ((m_words[i] & m) == (c & m));
            3'd4: for (int i = 0; i < NC; i++) begin
                      if (m_tags[i] && !done) done = 1'b1;
                      else m_tags[i] = 1'b0;
                  end
            3'd5: for (int i = 0; i < NC; i++)
                      if (m_tags[i]) m_words[i] = (m_words[i] & ~m) | (c & m);
            3'd6: for (int i = 0; i < NC; i++)
                      if (m_tags[i]) d = d | (m_words[i] & m);
            3'd7: for (int i = 0; i < NC; i++)
                      if (m_tags[i] && !done) begin
                          m_tags[i] = 1'b0;
                          done = 1'b1;
                      end
            default: ;
        endcase
        some = (m_tags != 0);
        idx = '0;
        cnt = '0;
        for (int i = NC - 1; i >= 0; i--) if (m_tags[i]) idx = 3'(i);
        for (int i = 0; i < NC; i++) cnt = cnt + 4'(m_tags[i]);
        exp_q.push_back({d, some, idx, m_tags, cnt});
    endfunction

    // scoreboard: every cycle a response is visible it must match the queue head
    always @(negedge CLK) begin
        logic [W-1:0] e;
        if (started && !RST) begin
            if (bus.rsp_valid) begin
                chk("cmd_ready_during_resp", bus.cmd_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("rsp_data", bus.rsp_data, e[19:16]);
                    chk("rsp_some", bus.rsp_some, e[15]);
                    chk("rsp_first_idx", bus.rsp_first_idx, e[14:12]);
                    chk("rsp_tags", tag_wires, e[11:4]);
`ifdef CAPP_TAG_COUNT_EN
                    chk("tag_count", tag_count, e[3:0]);
`endif
                    if (bus.rsp_ready) begin
                        last_data = bus.rsp_data;
                        last_some = bus.rsp_some;
                        last_idx  = bus.rsp_first_idx;
                        last_tags = tag_wires;
                        last_cnt  = tag_count;
                        exp_q.pop_front();
                    end
                end
            end else if (bus.cmd_ready) begin
                chk("idle_tags", tag_wires, m_tags);
            end
        end
    end

    // driver tasks: all called and returning at posedge+1
    task automatic send_cmd(input logic [2:0] op, input logic [3:0] c, input logic [3:0] m);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_comparand = c;
        bus.cmd_mask = m;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        model_apply(op, c, m);
    endtask

    task automatic get_rsp(input int hold);
        int n;
        bus.rsp_ready = (hold == 0);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_valid_timeout", 0, 1);
        repeat (hold) begin
            @(posedge CLK); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] c, input logic [3:0] m);
        send_cmd(op, c, m);
        get_rsp(0);
    endtask

    initial begin
        RST = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_comparand = '0;
        bus.cmd_mask = '0;
        bus.rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_tags", tag_wires, 8'h00);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_first_idx", bus.rsp_first_idx, 0);
        RST = 1'b0;
        started = 1'b1;

        run(3'd1, 4'h0, 4'h0);
        run(3'd6, 4'h0, 4'hF);
        chk("read_after_reset", last_data, 4'h0);

        // fill words 1..8 one cell at a time
        for (int i = 1; i <= 8; i++) begin
            run(3'd1, 4'h0, 4'h0);
            run(3'd3, 4'h0, 4'hF);
            run(3'd4, 4'h0, 4'h0);
            run(3'd5, 4'(i), 4'hF);
        end
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'h5, 4'hF);
        chk("fill_search5_tags", last_tags, 8'b0001_0000);
        chk("fill_search5_idx", last_idx, 4);
        run(3'd6, 4'h0, 4'hF);
        chk("fill_read5", last_data, 4'h5);

        // odd words, then drop the first
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'h1, 4'h1);
        chk("odd_tags", last_tags, 8'b0101_0101);
`ifdef CAPP_TAG_COUNT_EN
        chk("odd_count", last_cnt, 4);
`endif
        run(3'd3, 4'h5, 4'h0);
        chk("mask0_search_tags", last_tags, 8'b0101_0101);
        run(3'd7, 4'h0, 4'h0);
        chk("select_next_tags", last_tags, 8'b0101_0100);
        chk("select_next_idx", last_idx, 2);

        // no match: select/write are no-ops
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'hF, 4'hF);
        chk("nomatch_some", last_some, 0);
        chk("nomatch_idx", last_idx, 0);
        run(3'd4, 4'h0, 4'h0);
        chk("nomatch_select_first", last_tags, 8'h00);
        run(3'd5, 4'h3, 4'hF);
        run(3'd7, 4'h0, 4'h0);
        chk("nomatch_select_next", last_tags, 8'h00);
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'h3, 4'hF);
        chk("words_unchanged", last_tags, 8'b0000_0100);

        // masked multi-write sets bit 3 in words holding bit 1
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'h2, 4'h2);
        chk("bit1_tags", last_tags, 8'b0110_0110);
        run(3'd5, 4'h8, 4'h8);
        run(3'd6, 4'h0, 4'h8);
        chk("masked_read", last_data, 4'h8);
        run(3'd1, 4'h0, 4'h0);
        run(3'd3, 4'h8, 4'h8);
        chk("bit3_tags", last_tags, 8'b1110_0110);
        run(3'd6, 4'h0, 4'h7);
        chk("bit3_read", last_data, 4'h7);

        // backpressure with a command offered during the stalled response
        send_cmd(3'd6, 4'h0, 4'hF);
        bus.rsp_ready = 1'b0;
        @(posedge CLK); #1;
        chk("bp_rsp_valid_start", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd2;
        bus.cmd_comparand = 4'h0;
        bus.cmd_mask = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_ready", bus.cmd_ready, 1);
        chk("bp_read_data", last_data, 4'hF);
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        chk("bp_taken", bus.cmd_ready, 0);
        model_apply(3'd2, 4'h0, 4'h0);
        get_rsp(0);
        chk("bp_clear_tags", last_tags, 8'h00);

        // reset during EXEC of a WRITE aborts it
        run(3'd1, 4'h0, 4'h0);
        send_cmd(3'd5, 4'hA, 4'hF);
        void'(exp_q.pop_back());
        chk("abort_in_exec", dbg_state, ST_EXEC);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_tags", tag_wires, 8'h00);
        run(3'd1, 4'h0, 4'h0);
        run(3'd6, 4'h0, 4'hF);
        chk("abort_words_zero", last_data, 4'h0);

        repeat (2) @(posedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", tests, bad);
        $finish;
    end

endmodule
